// File: rtl/example_sync_event_capture.sv
// Debounce a synchronized level, turn each accepted transition into a rise/fall
// event and offer it on a valid/ready handshake. Events that arrive while the
// consumer stalls on a pending event are dropped and counted (saturating).
module example_sync_event_capture #(
  parameter int   FILTER_CYCLES = 4,
  parameter int   DROP_CNT_W    = 8,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SYNC_I,
  output logic                  FILT_O,
  output logic                  EVT_VALID,
  input  logic                  EVT_READY,
  output logic                  EVT_RISE,
  input  logic                  CLR_OVF,
  output logic                  OVF,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  if (FILTER_CYCLES < 1 || DROP_CNT_W < 1) begin : g_param_err
    $error("example_sync_event_capture: FILTER_CYCLES and DROP_CNT_W must be >= 1");
  end

  localparam int CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
  // Counter value that, together with one more differing sample, completes a run.
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'((FILTER_CYCLES < 1) ? 0 : FILTER_CYCLES - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  logic                  filt_q, filt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic                  rise_q, rise_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  evt;
  logic                  drop;

  // Stable-run filter: accept the new level on the FILTER_CYCLES-th differing sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    evt    = 1'b0;
    if (SYNC_I != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = SYNC_I;
        evt    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output handshake FSM; a new event while stalled on a pending one is dropped.
  always_comb begin
    state_d = state_q;
    rise_d  = rise_q;
    drop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (evt) begin
          state_d = S_PEND;
          rise_d  = SYNC_I;
        end
      end
      S_PEND: begin
        if (EVT_READY) begin
          if (evt) rise_d  = SYNC_I;
          else     state_d = S_IDLE;
        end else if (evt) begin
          drop = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky overflow and saturating drop count; a drop beats a coincident clear.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      if (CLR_OVF)               drop_d = DROP_CNT_W'(1);
      else if (drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
    end else if (CLR_OVF) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt_q  <= RESET_LEVEL;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      rise_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign FILT_O    = filt_q;
  assign EVT_VALID = (state_q == S_PEND);
  assign EVT_RISE  = rise_q;
  assign OVF       = ovf_q;
  assign DROP_CNT  = drop_q;

endmodule

// File: tb/tb_example_sync_event_capture.sv
// Bench for example_sync_event_capture. Two instances share all inputs:
// dut_a uses FILTER_CYCLES=4 / DROP_CNT_W=8, dut_b uses FILTER_CYCLES=1 / DROP_CNT_W=2.
module tb_example_sync_event_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sync_i = 1'b0;
  logic       ready = 1'b1;
  logic       clr = 1'b0;

  logic       a_filt, a_valid, a_rise, a_ovf;
  logic [7:0] a_drop;
  logic       b_filt, b_valid, b_rise, b_ovf;
  logic [1:0] b_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  example_sync_event_capture #(.FILTER_CYCLES(4), .DROP_CNT_W(8), .RESET_LEVEL(1'b0)) dut_a (
    .CLK(clk), .RST(rst), .SYNC_I(sync_i), .FILT_O(a_filt), .EVT_VALID(a_valid),
    .EVT_READY(ready), .EVT_RISE(a_rise), .CLR_OVF(clr), .OVF(a_ovf), .DROP_CNT(a_drop)
  );

  example_sync_event_capture #(.FILTER_CYCLES(1), .DROP_CNT_W(2), .RESET_LEVEL(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .SYNC_I(sync_i), .FILT_O(b_filt), .EVT_VALID(b_valid),
    .EVT_READY(ready), .EVT_RISE(b_rise), .CLR_OVF(clr), .OVF(b_ovf), .DROP_CNT(b_drop)
  );

  // ---------------- reference model (per instance k) ----------------
  int FCS [2] = '{4, 1};
  int WS  [2] = '{8, 2};
  bit sync_hist[$];        // every sampled SYNC_I since reset
  int since  [2];          // index of the first sample after the last level change
  bit m_filt [2];
  bit m_pend [2];
  bit m_rise [2];
  bit m_ovf  [2];
  int m_nd   [2];          // drops since last clear, unbounded

  task automatic model_reset();
    sync_hist.delete();
    for (int k = 0; k < 2; k++) begin
      since[k] = 0; m_filt[k] = 1'b0; m_pend[k] = 1'b0;
      m_rise[k] = 1'b0; m_ovf[k] = 1'b0; m_nd[k] = 0;
    end
  endtask

  // New level is accepted once the most recent FC samples since the last change all differ.
  task automatic model_edge(input bit s, input bit r, input bit c);
    sync_hist.push_back(s);
    for (int k = 0; k < 2; k++) begin
      bit evt, all_diff, dropped;
      int n;
      n = sync_hist.size();
      evt = 1'b0;
      if (n - since[k] >= FCS[k]) begin
        all_diff = 1'b1;
        for (int i = n - FCS[k]; i < n; i++)
          if (sync_hist[i] == m_filt[k]) all_diff = 1'b0;
        if (all_diff) begin
          evt = 1'b1;
          m_filt[k] = s;
          since[k] = n;
        end
      end
      dropped = 1'b0;
      if (!m_pend[k]) begin
        if (evt) begin m_pend[k] = 1'b1; m_rise[k] = s; end
      end else if (r) begin
        if (evt) m_rise[k] = s;
        else     m_pend[k] = 1'b0;
      end else if (evt) begin
        dropped = 1'b1;
      end
      if (dropped) begin
        m_ovf[k] = 1'b1;
        m_nd[k]  = c ? 1 : m_nd[k] + 1;
      end else if (c) begin
        m_ovf[k] = 1'b0;
        m_nd[k]  = 0;
      end
    end
  endtask

  function automatic int exp_drop(input int k);
    int mx;
    mx = (1 << WS[k]) - 1;
    return (m_nd[k] > mx) ? mx : m_nd[k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_models();
    chk("a_filt_model",  {31'd0, a_filt},  {31'd0, m_filt[0]});
    chk("a_valid_model", {31'd0, a_valid}, {31'd0, m_pend[0]});
    chk("a_rise_model",  {31'd0, a_rise},  {31'd0, m_rise[0]});
    chk("a_ovf_model",   {31'd0, a_ovf},   {31'd0, m_ovf[0]});
    chk("a_drop_model",  {24'd0, a_drop},  exp_drop(0));
    chk("b_filt_model",  {31'd0, b_filt},  {31'd0, m_filt[1]});
    chk("b_valid_model", {31'd0, b_valid}, {31'd0, m_pend[1]});
    chk("b_rise_model",  {31'd0, b_rise},  {31'd0, m_rise[1]});
    chk("b_ovf_model",   {31'd0, b_ovf},   {31'd0, m_ovf[1]});
    chk("b_drop_model",  {30'd0, b_drop},  exp_drop(1));
  endtask

  // Apply inputs, take one edge, update model, compare 1 time unit later.
  task automatic step(input bit s, input bit r, input bit c);
    sync_i = s; ready = r; clr = c;
    @(posedge clk);
    model_edge(s, r, c);
    #1;
    check_models();
  endtask

  task automatic check_reset_values();
    chk("rst_a_filt",  {31'd0, a_filt},  0);
    chk("rst_a_valid", {31'd0, a_valid}, 0);
    chk("rst_a_rise",  {31'd0, a_rise},  0);
    chk("rst_a_ovf",   {31'd0, a_ovf},   0);
    chk("rst_a_drop",  {24'd0, a_drop},  0);
    chk("rst_b_filt",  {31'd0, b_filt},  0);
    chk("rst_b_valid", {31'd0, b_valid}, 0);
    chk("rst_b_drop",  {30'd0, b_drop},  0);
  endtask

  task automatic do_reset();
    sync_i = 1'b0; ready = 1'b1; clr = 1'b0;
    rst = 1'b1;
    #2;
    check_reset_values();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed table for dut_a ----------------
  typedef struct {
    bit       s, r, c;
    bit       f, v, rise, o;
    bit [7:0] d;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit s, r, c, f, v, rise, o, input bit [7:0] d, input int n);
    vec_t e;
    e.s = s; e.r = r; e.c = c; e.f = f; e.v = v; e.rise = rise; e.o = o; e.d = d;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    bit s, held_rise;

    // glitch of 3 samples rejected
    add(1,1,0, 0,0,0,0,0, 3);
    add(0,1,0, 0,0,0,0,0, 2);
    // clean rise, consumer ready: one-cycle event on the 4th edge
    add(1,1,0, 0,0,0,0,0, 3);
    add(1,1,0, 1,1,1,0,0, 1);
    add(1,1,0, 1,0,1,0,0, 2);
    // clean fall back to 0
    add(0,1,0, 1,0,1,0,0, 3);
    add(0,1,0, 0,1,0,0,0, 1);
    add(0,1,0, 0,0,0,0,0, 1);
    // stall: rise pending, later fall dropped
    add(1,0,0, 0,0,0,0,0, 3);
    add(1,0,0, 1,1,1,0,0, 1);
    add(0,0,0, 1,1,1,0,0, 3);
    add(0,0,0, 0,1,1,1,1, 1);
    add(0,1,0, 0,0,1,1,1, 1);
    add(0,1,1, 0,0,1,0,0, 1);

    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_filt", i),  {31'd0, a_filt},  {31'd0, tbl[i].f});
      chk($sformatf("tbl%0d_valid", i), {31'd0, a_valid}, {31'd0, tbl[i].v});
      chk($sformatf("tbl%0d_rise", i),  {31'd0, a_rise},  {31'd0, tbl[i].rise});
      chk($sformatf("tbl%0d_ovf", i),   {31'd0, a_ovf},   {31'd0, tbl[i].o});
      chk($sformatf("tbl%0d_drop", i),  {24'd0, a_drop},  {24'd0, tbl[i].d});
    end

    // back-to-back events on dut_b (FILTER_CYCLES=1): valid held, rise alternating
    step(0, 1, 0);
    step(0, 1, 0);
    chk("b2b_pre_valid", {31'd0, b_valid}, 0);
    s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s = ~s;
      step(s, 1, 0);
      chk("b2b_filt",  {31'd0, b_filt},  {31'd0, s});
      chk("b2b_valid", {31'd0, b_valid}, 1);
      chk("b2b_rise",  {31'd0, b_rise},  {31'd0, s});
      chk("b2b_drop",  {30'd0, b_drop},  0);
    end

    // saturation on dut_b (DROP_CNT_W=2): still pending, 5 drops while stalled
    held_rise = b_rise;
    for (int i = 0; i < 5; i++) begin
      s = ~s;
      step(s, 0, 0);
      chk("sat_rise_stable", {31'd0, b_rise}, {31'd0, held_rise});
    end
    chk("sat_drop",  {30'd0, b_drop},  3);
    chk("sat_ovf",   {31'd0, b_ovf},   1);
    chk("sat_valid", {31'd0, b_valid}, 1);
    // clear coincident with a drop: drop wins
    s = ~s;
    step(s, 0, 1);
    chk("clr_drop_wins_ovf", {31'd0, b_ovf},  1);
    chk("clr_drop_wins_cnt", {30'd0, b_drop}, 1);
    step(s, 0, 1);
    chk("clr_plain_ovf", {31'd0, b_ovf},  0);
    chk("clr_plain_cnt", {30'd0, b_drop}, 0);

    // reset mid-operation on dut_a
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("mid_pre_valid", {31'd0, a_valid}, 1);
    rst = 1'b1;
    #2;
    chk("mid_rst_filt",  {31'd0, a_filt},  0);
    chk("mid_rst_valid", {31'd0, a_valid}, 0);
    chk("mid_rst_rise",  {31'd0, a_rise},  0);
    chk("mid_rst_ovf",   {31'd0, a_ovf},   0);
    chk("mid_rst_drop",  {24'd0, a_drop},  0);
    model_reset();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 0);
      chk($sformatf("mid_post%0d_valid", i), {31'd0, a_valid}, (i == 4) ? 1 : 0);
      chk($sformatf("mid_post%0d_filt", i),  {31'd0, a_filt},  (i == 4) ? 1 : 0);
    end
    chk("mid_post_rise", {31'd0, a_rise}, 1);

    // randomized traffic against the model
    do_reset();
    s = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      bit r, c;
      if ((i / 200) % 2 == 0) begin
        if ($urandom_range(2) == 0) s = ~s;
      end else begin
        if ($urandom_range(6) == 0) s = ~s;
      end
      r = ($urandom_range(3) != 0);
      c = ($urandom_range(19) == 0);
      step(s, r, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
